// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register master: FSM state encoding,
// default frame geometry and divider width.
// No ports; imported by spi_clk_gen and spi_reg_master.
package spi_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_REG_WIDTH  = 8;
    localparam int DEF_FRAME      = 1 + DEF_ADDR_WIDTH + DEF_REG_WIDTH;

    // Divider counter width; CLK_DIV tops out at 255.
    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // One R/W bit, then address, then data.
    function automatic int frame_bits(input int aw, input int rw);
        return 1 + aw + rw;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: phase divider, leading/trailing edge strobes, spi_clk register.
// Latency: strobes are combinational from the divider; spi_clk toggles one cycle after a strobe.
// Backpressure: none; i_ena low freezes the divider and spi_clk.
// Ports: clk/rst (async active-high), i_ena clock enable, i_run (frame active),
//        i_edge_en (current phase emits spi_clk edges), i_cpol live polarity (idle follow),
//        i_cpol_cap captured polarity, o_tick phase-end strobe, o_lead/o_trail edge strobes,
//        o_spi_clk registered SPI clock.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ena,
    input  logic i_run,
    input  logic i_edge_en,
    input  logic i_cpol,
    input  logic i_cpol_cap,
    output logic o_tick,
    output logic o_lead,
    output logic o_trail,
    output logic o_spi_clk
);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_edge;

    // Tick fires on the last cycle of each CLK_DIV-long slot; every FSM phase
    // boundary and every spi_clk edge lands on the register update after it.
    assign o_tick  = i_ena && i_run && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_edge  = o_tick && i_edge_en;
    // Leading edge leaves the idle level, trailing edge returns to it.
    assign o_lead  = w_edge && (r_sclk == i_cpol_cap);
    assign o_trail = w_edge && (r_sclk != i_cpol_cap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (i_ena) begin
            if (!i_run || o_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            // Idle: track the live polarity so the bus idles correctly before
            // the first frame. During a frame only real edges move it.
            if (!i_run) begin
                r_sclk <= i_cpol;
            end else if (w_edge) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

    assign o_spi_clk = r_sclk;

endmodule

// File: rtl/spi_reg_master.sv
// SPI register-access master: one R/W bit, address and data per chip-select frame.
// Latency: busy/cs_n one cycle after start; done at T+1+(2*FRAME+1)*CLK_DIV.
// Backpressure: start while busy is dropped; ena low freezes every register.
// Ports: clk, rst (async active-high), ena clock enable, cpol/cpha SPI mode,
//        start/wr/addr/wdata request, busy/done/rdata status, spi_cs_n/spi_clk/
//        spi_mosi/spi_miso SPI pins. All outputs are registered.
module spi_reg_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int FRAME    = frame_bits(ADDR_WIDTH, REG_WIDTH);
    localparam int EDGES    = 2 * FRAME;
    localparam int EW       = $clog2(EDGES + 1);
    // Sample index of the first data bit; earlier samples are command echo.
    localparam int RX_FIRST = FRAME - REG_WIDTH;

    spi_state_t           r_state, w_state_nxt;
    logic [EW-1:0]        r_edge, w_edge_nxt;
    logic [FRAME-1:0]     r_tx, w_tx_nxt;
    logic [REG_WIDTH-1:0] r_rx, w_rx_nxt;
    logic                 r_wr, w_wr_nxt;
    logic                 r_cpol, w_cpol_nxt;
    logic                 r_cpha, w_cpha_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_cs_n, w_cs_n_nxt;
    logic                 r_mosi, w_mosi_nxt;
    logic [REG_WIDTH-1:0] r_rdata, w_rdata_nxt;

    logic                 w_run;
    logic                 w_edge_en;
    logic                 w_tick;
    logic                 w_lead;
    logic                 w_trail;
    logic                 w_shift;
    logic                 w_sample;
    logic [FRAME-1:0]     w_frame;

    assign w_run     = (r_state != ST_IDLE);
    assign w_edge_en = (r_state == ST_SETUP) || (r_state == ST_XFER);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_ena      (ena),
        .i_run      (w_run),
        .i_edge_en  (w_edge_en),
        .i_cpol     (cpol),
        .i_cpol_cap (r_cpol),
        .o_tick     (w_tick),
        .o_lead     (w_lead),
        .o_trail    (w_trail),
        .o_spi_clk  (spi_clk)
    );

    // cpha=0: sample leading, shift trailing. cpha=1: the reverse.
    assign w_shift  = r_cpha ? w_lead  : w_trail;
    assign w_sample = r_cpha ? w_trail : w_lead;

    // Reads clock out zeros in the data field.
    assign w_frame = {wr, addr, (wr ? wdata : {REG_WIDTH{1'b0}})};

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = r_edge;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_wr_nxt    = r_wr;
        w_cpol_nxt  = r_cpol;
        w_cpha_nxt  = r_cpha;
        w_cs_n_nxt  = r_cs_n;
        w_mosi_nxt  = r_mosi;
        w_done_nxt  = 1'b0;
        w_rdata_nxt = r_rdata;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETUP;
                    w_wr_nxt    = wr;
                    w_cpol_nxt  = cpol;
                    w_cpha_nxt  = cpha;
                    w_edge_nxt  = '0;
                    w_cs_n_nxt  = 1'b0;
                    if (cpha) begin
                        // First bit goes out on the first leading edge.
                        w_tx_nxt   = w_frame;
                        w_mosi_nxt = 1'b0;
                    end else begin
                        // First bit must already be on the wire at cs_n fall.
                        w_tx_nxt   = w_frame << 1;
                        w_mosi_nxt = w_frame[FRAME-1];
                    end
                end
            end
            ST_SETUP, ST_XFER: begin
                // SETUP's closing tick produces edge 1; XFER covers the rest.
                if (w_tick) begin
                    w_edge_nxt = r_edge + EW'(1);
                    if (r_edge == EW'(EDGES - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_XFER;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = ST_GAP;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    if (!r_wr) begin
                        w_rdata_nxt = r_rx;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_shift) begin
            w_mosi_nxt = r_tx[FRAME-1];
            w_tx_nxt   = r_tx << 1;
        end

        // Sample index = edges so far / 2 for both phases.
        if (w_sample && (r_edge[EW-1:1] >= (EW-1)'(RX_FIRST))) begin
            w_rx_nxt = {r_rx[REG_WIDTH-2:0], spi_miso};
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_edge  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_wr    <= 1'b0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_rdata <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_edge  <= w_edge_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_wr    <= w_wr_nxt;
            r_cpol  <= w_cpol_nxt;
            r_cpha  <= w_cpha_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_mosi  <= w_mosi_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_reg_master.sv
`timescale 1ns/1ps
module tb_spi_reg_master;

    localparam int D  = 2;
    localparam int F  = 16;
    localparam int N_CSRISE   = (2*F+1)*D + 1;   // cycle index (from T) of cs_n rise / done
    localparam int N_BUSYFALL = (2*F+2)*D + 1;   // cycle index of busy fall

    logic       clk = 1'b0;
    logic       rst, ena, cpol, cpha, start, wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, spi_cs_n, spi_clk, spi_mosi;
    logic [7:0] rdata;
    logic       spi_miso = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    spi_reg_master #(
        .CLK_DIV    (D),
        .ADDR_WIDTH (7),
        .REG_WIDTH  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .cpol     (cpol),
        .cpha     (cpha),
        .start    (start),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- test-level mode and responder data ----------------
    logic        t_cpol = 1'b0;
    logic        t_cpha = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic [15:0] resp_word;
    assign resp_word = {8'hC3, resp_data};   // command-phase junk, then data

    // ---------------- behavioural model (timeline from acceptance) ------
    logic        m_act, m_cpol, m_cpha, m_wr, m_idle_cpol;
    int          m_n;
    logic [15:0] m_frame;
    logic [7:0]  m_resp, m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0; m_n = 0; m_rdata = 8'h00; m_idle_cpol = 1'b0;
        end else if (ena) begin
            if (!m_act) begin
                m_idle_cpol = cpol;
                if (start) begin
                    m_act = 1'b1; m_n = 1;
                    m_cpol = cpol; m_cpha = cpha; m_wr = wr;
                    m_frame = {wr, addr, (wr ? wdata : 8'h00)};
                    m_resp = resp_data;
                end
            end else begin
                m_n = m_n + 1;
                if (m_n == N_CSRISE && !m_wr) m_rdata = m_resp;
                if (m_n == N_BUSYFALL) m_act = 1'b0;
            end
        end
    end

    int   c_e, c_idx;
    logic c_busy, c_done, c_cs_n, c_sclk, c_mosi;

    always @(negedge clk) begin
        if (m_act) begin
            c_e = (m_n - 1) / D;
            if (c_e > 2*F) c_e = 2*F;
            c_busy = 1'b1;
            c_cs_n = (m_n >= N_CSRISE);
            c_done = (m_n == N_CSRISE);
            c_sclk = m_cpol ^ c_e[0];
            if (c_cs_n) begin
                c_mosi = 1'b0;
            end else if (!m_cpha) begin
                c_idx  = c_e / 2;                      // trailing edges so far
                c_mosi = (c_idx < F) ? m_frame[F-1-c_idx] : 1'b0;
            end else begin
                c_idx  = (c_e + 1) / 2;                // leading edges so far
                c_mosi = (c_idx == 0) ? 1'b0 : m_frame[F-c_idx];
            end
        end else begin
            c_busy = 1'b0; c_done = 1'b0; c_cs_n = 1'b1;
            c_sclk = m_idle_cpol; c_mosi = 1'b0;
        end
        check("busy",     busy,     c_busy);
        check("done",     done,     c_done);
        check("spi_cs_n", spi_cs_n, c_cs_n);
        check("spi_clk",  spi_clk,  c_sclk);
        check("spi_mosi", spi_mosi, c_mosi);
        check("rdata",    rdata,    m_rdata);
    end

    // ---------------- monitor + SPI responder ----------------
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    int          r_cnt = 0, n_edge = 0, n_csfall = 0, n_done = 0;
    int          ev_csfall = 0, ev_csrise = 0, ev_done = 0, ev_busyfall = 0, ev_edge1 = 0;
    logic [15:0] mosi_word = 16'h0;

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            ev_csfall = cyc; n_csfall++; n_edge = 0; mosi_word = 16'h0; r_cnt = 0;
        end
        if (!prev_cs && spi_cs_n) ev_csrise = cyc;
        if (done) begin ev_done = cyc; n_done++; end
        if (prev_busy && !busy) ev_busyfall = cyc;
        if (!spi_cs_n && (spi_clk != prev_sclk)) begin
            n_edge++;
            if (n_edge == 1) ev_edge1 = cyc;
            // sample edge = leading for cpha=0, trailing for cpha=1
            if ((spi_clk != t_cpol) ^ t_cpha) mosi_word = {mosi_word[14:0], spi_mosi};
            else r_cnt++;
        end
        if (spi_cs_n) begin
            r_cnt = 0; spi_miso = 1'b0;
        end else if (!t_cpha) begin
            spi_miso = (r_cnt < F) ? resp_word[F-1-r_cnt] : 1'b0;
        end else begin
            spi_miso = (r_cnt >= 1 && r_cnt <= F) ? resp_word[F-r_cnt] : 1'b0;
        end
        prev_cs = spi_cs_n; prev_sclk = spi_clk; prev_busy = busy;
    end

    // ---------------- stimulus ----------------
    int t_start;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p; cpha = h; t_cpol = p; t_cpha = h;
        tick(3);
    endtask

    task automatic launch(input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] resp);
        resp_data = resp; wr = w; addr = a; wdata = d; start = 1'b1; t_start = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin tick(1); k++; end while (busy && k < budget);
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t1, nd0, nc0;
    logic [3:0] snap;

    initial begin
        rst = 1'b1; ena = 1'b1; cpol = 1'b0; cpha = 1'b0; start = 1'b0;
        wr = 1'b0; addr = 7'h0; wdata = 8'h0;
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_clk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        tick(2);

        // Mode 3 read
        set_mode(1'b1, 1'b1);
        check("m3_sclk_before", spi_clk, 1'b1);
        launch(1'b0, 7'h10, 8'hFF, 8'h3C);
        wait_idle(200);
        check("m3_mosi_word", mosi_word, 16'h1000);
        check("m3_rdata", rdata, 8'h3C);
        check("m3_sclk_after", spi_clk, 1'b1);
        check("m3_edges", n_edge, 32);

        // Mode 2 read
        set_mode(1'b1, 1'b0);
        launch(1'b0, 7'h2A, 8'h00, 8'h81);
        wait_idle(200);
        check("m2_mosi_word", mosi_word, 16'h2A00);
        check("m2_rdata", rdata, 8'h81);

        // Mode 0 write, timing pins
        set_mode(1'b0, 1'b0);
        launch(1'b1, 7'h05, 8'hA5, 8'h00);
        wait_idle(200);
        check("m0_mosi_word", mosi_word, 16'h85A5);
        check("m0_csfall_ofs", ev_csfall - t_start, 1);
        check("m0_edge1_ofs", ev_edge1 - t_start, 3);
        check("m0_csrise_ofs", ev_csrise - t_start, 67);
        check("m0_done_ofs", ev_done - t_start, 67);
        check("m0_busyfall_ofs", ev_busyfall - t_start, 69);
        check("m0_wr_rdata_kept", rdata, 8'h81);

        // ena low for 7 cycles mid-transfer
        launch(1'b0, 7'h33, 8'h00, 8'h5A);
        tick(20);
        ena = 1'b0;
        snap = {spi_cs_n, spi_clk, spi_mosi, busy};
        tick(6);
        check("ena_frozen", {spi_cs_n, spi_clk, spi_mosi, busy}, snap);
        tick(1);
        ena = 1'b1;
        wait_idle(200);
        check("ena_done_ofs", ev_done - t_start, 74);
        check("ena_busyfall_ofs", ev_busyfall - t_start, 76);
        check("ena_rdata", rdata, 8'h5A);
        check("ena_mosi_word", mosi_word, 16'h3300);

        // Mode 1 read
        set_mode(1'b0, 1'b1);
        launch(1'b0, 7'h2A, 8'h00, 8'h81);
        wait_idle(200);
        check("m1_mosi_word", mosi_word, 16'h2A00);
        check("m1_rdata", rdata, 8'h81);

        // start held high for the whole busy window: one frame only
        set_mode(1'b0, 1'b0);
        nd0 = n_done; nc0 = n_csfall;
        resp_data = 8'h00; wr = 1'b1; addr = 7'h0F; wdata = 8'h3C;
        start = 1'b1; t_start = cyc;
        for (int i = 1; i <= 68; i++) begin
            tick(1);
            if (i == 5)  begin addr = 7'h7F; wdata = 8'h00; wr = 1'b0; cpol = 1'b1; cpha = 1'b1; end
            if (i == 60) begin cpol = 1'b0; cpha = 1'b0; end
        end
        tick(1);
        start = 1'b0;
        tick(5);
        check("hold_frames", n_csfall - nc0, 1);
        check("hold_dones", n_done - nd0, 1);
        check("hold_mosi_word", mosi_word, 16'h8F3C);

        // back-to-back: start in the busy-fall cycle
        nd0 = n_done;
        launch(1'b1, 7'h01, 8'h11, 8'h00);
        t1 = t_start;
        wait_idle(200);
        check("b2b_busyfall_ofs", cyc - t1, 69);
        launch(1'b1, 7'h02, 8'h22, 8'h00);
        check("b2b_csfall_ofs", ev_csfall - t1, 70);
        wait_idle(200);
        check("b2b_dones", n_done - nd0, 2);
        check("b2b_mosi_word", mosi_word, 16'h8222);

        // reset at the 10th spi_clk edge of a read
        launch(1'b0, 7'h11, 8'h00, 8'h99);
        for (int k = 0; k < 200 && n_edge < 10; k++) tick(1);
        check("rst_edge_reached", n_edge, 10);
        nd0 = n_done; nc0 = n_csfall;
        rst = 1'b1;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sclk", spi_clk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_rdata", rdata, 8'h00);
        tick(3);
        rst = 1'b0;
        tick(30);
        check("abort_no_done", n_done - nd0, 0);
        check("abort_no_frame", n_csfall - nc0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
